// File: rtl/apu_dma_pkg.sv
// Shared types and constants for the APU DMA scheduler.
package apu_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_DUMMY,
    ST_ALIGN,
    ST_OAM_GET,
    ST_OAM_PUT,
    ST_DMC_GET
  } dma_state_t;

  localparam logic [15:0] OAM_PORT    = 16'h2004;
  localparam int unsigned OAM_LEN     = 256;
  localparam logic        DMC_ADDR_HI = 1'b1;

endpackage

// File: rtl/apu_dma_scheduler.sv
// CPU-bus DMA scheduler: OAM sprite DMA and DMC sample fetches, DMC has priority.
module apu_dma_scheduler
  import apu_dma_pkg::*;
#(
  parameter logic [15:0] OAM_PORT = apu_dma_pkg::OAM_PORT,
  parameter int unsigned OAM_LEN  = apu_dma_pkg::OAM_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_clk,
  input  logic        cpu_read,
  input  logic        oam_wren,
  input  logic [7:0]  from_cpu,
  input  logic        dmc_dma_req,
  input  logic [14:0] dmc_address,
  output logic        dmc_dma_ack,
  input  logic [7:0]  from_mem,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] dma_address,
  output logic        dma_rw,
  output logic [7:0]  to_mem
);

  localparam logic [7:0] IDX_LAST = 8'(OAM_LEN - 1);

  dma_state_t  state_q, state_d;
  logic        put_phase_q;
  logic        oam_pending_q, oam_pending_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  index_q, index_d;
  logic [15:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [7:0]  to_mem_q, to_mem_d;
  logic        next_get;

  // The current cycle is a put cycle exactly when the following one is a get.
  assign next_get = put_phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      put_phase_q   <= 1'b0;
      oam_pending_q <= 1'b0;
      page_q        <= '0;
      index_q       <= '0;
      addr_q        <= '0;
      rw_q          <= 1'b1;
      to_mem_q      <= '0;
    end else begin
      if (cpu_clk) begin
        put_phase_q <= ~put_phase_q;
      end
      state_q       <= state_d;
      oam_pending_q <= oam_pending_d;
      page_q        <= page_d;
      index_q       <= index_d;
      addr_q        <= addr_d;
      rw_q          <= rw_d;
      to_mem_q      <= to_mem_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    oam_pending_d = oam_pending_q;
    page_d        = page_q;
    index_d       = index_q;
    addr_d        = addr_q;
    rw_d          = rw_q;
    to_mem_d      = to_mem_q;

    if (cpu_clk) begin
      unique case (state_q)
        ST_IDLE: begin
          if ((oam_pending_q | dmc_dma_req) & cpu_read) begin
            state_d = ST_HALT;
          end
          if (oam_wren) begin
            oam_pending_d = 1'b1;
            page_d        = from_cpu;
            index_d       = '0;
          end
        end
        ST_HALT: begin
          if (dmc_dma_req) begin
            state_d = ST_DUMMY;
          end else if (oam_pending_q) begin
            state_d = next_get ? ST_OAM_GET : ST_ALIGN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DUMMY: begin
          if (dmc_dma_req) begin
            state_d = next_get ? ST_DMC_GET : ST_ALIGN;
          end else if (oam_pending_q) begin
            state_d = next_get ? ST_OAM_GET : ST_ALIGN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ALIGN: begin
          if (dmc_dma_req) begin
            state_d = ST_DMC_GET;
          end else if (oam_pending_q) begin
            state_d = ST_OAM_GET;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DMC_GET: begin
          state_d = oam_pending_q ? ST_ALIGN : ST_IDLE;
        end
        ST_OAM_GET: begin
          to_mem_d = from_mem;
          state_d  = ST_OAM_PUT;
        end
        ST_OAM_PUT: begin
          index_d = index_q + 8'd1;
          if (index_q == IDX_LAST) begin
            oam_pending_d = 1'b0;
          end
          if (dmc_dma_req) begin
            state_d = ST_DMC_GET;
          end else if (index_q != IDX_LAST) begin
            state_d = ST_OAM_GET;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Bus address and direction are registered for the cycle being entered;
      // HALT/DUMMY/ALIGN/IDLE keep the previous address on the bus.
      unique case (state_d)
        ST_DMC_GET: begin
          addr_d = {DMC_ADDR_HI, dmc_address};
          rw_d   = 1'b1;
        end
        ST_OAM_GET: begin
          addr_d = {page_d, index_d};
          rw_d   = 1'b1;
        end
        ST_OAM_PUT: begin
          addr_d = OAM_PORT;
          rw_d   = 1'b0;
        end
        default: rw_d = 1'b1;
      endcase
    end
  end

  assign cpu_rdy     = (state_q == ST_IDLE);
  assign dma_active  = (state_q != ST_IDLE);
  assign dmc_dma_ack = (state_q == ST_DMC_GET);
  assign dma_address = addr_q;
  assign dma_rw      = rw_q;
  assign to_mem      = to_mem_q;

endmodule
